// File: rtl/aes_pkg.sv
// Shared types for the AES256 datapath: block geometry,
// byte/block typedefs and the block loader state encoding.
package aes_pkg;

   localparam int AES_N_BYTES = 16;

   typedef logic [7:0] byte_t;
   typedef byte_t [AES_N_BYTES-1:0] block_t;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      ISSUE
   } loader_state_t;

endpackage

// File: rtl/mod_blk_loader.sv
// Byte-serial block loader: assembles N bytes into a block, pads
// short final blocks, and strobes wr_en once downstream is free.
// Ports:
//   clk, reset         clock, sync active-high reset
//   in_valid/in_data/in_last/in_ready  byte stream handshake
//   dst_busy           downstream cannot accept a block
//   blk_o, wr_en       assembled block and one-cycle write strobe
//   pad_flag           last issued/current block has padding
//   blk_cnt            wrapping count of issued blocks
module mod_blk_loader
   import aes_pkg::*;
#(
   parameter int          N         = AES_N_BYTES,
   parameter logic [7:0]  PAD_BYTE  = 8'h00,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              dst_busy,
   output logic [N-1:0][7:0] blk_o,
   output logic              wr_en,
   output logic              pad_flag,
   output logic [15:0]       blk_cnt
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   loader_state_t     state_q;
   loader_state_t     state_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     idx;
   logic [N-1:0][7:0] blk_q;
   logic              pad_q;
   logic [15:0]       bcnt_q;
   logic              take;

   assign take = in_valid && in_ready;
   assign idx  = LSB_FIRST ? cnt_q : (LAST - cnt_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL: begin
            if (take) begin
               // a full block wins over in_last on the final byte
               if (cnt_q == LAST) begin
                  state_d = ISSUE;
               end else if (in_last) begin
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            if (cnt_q == LAST) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!dst_busy) begin
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      wr_en    = 1'b0;
      if (!reset) begin
         in_ready = (state_q == FILL);
         wr_en    = (state_q == ISSUE) && !dst_busy;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         blk_q  <= '0;
         pad_q  <= 1'b0;
         bcnt_q <= '0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (take) begin
                  blk_q[idx] <= in_data;
                  cnt_q      <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     pad_q <= 1'b0;
                  end else if (in_last) begin
                     pad_q <= 1'b1;
                  end
               end
            end
            PAD: begin
               blk_q[idx] <= PAD_BYTE;
               cnt_q      <= cnt_q + 1'b1;
            end
            ISSUE: begin
               if (!dst_busy) begin
                  cnt_q  <= '0;
                  bcnt_q <= bcnt_q + 16'd1;
               end
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

   assign blk_o    = blk_q;
   assign pad_flag = pad_q;
   assign blk_cnt  = bcnt_q;

endmodule

// File: tb/tb_mod_blk_loader.sv
// Self-checking bench for mod_blk_loader: two instances (LSB and
// MSB first) share one stimulus stream and a message-level model.
module tb_mod_blk_loader;

   localparam int N = 16;
   localparam logic [7:0] PADB = 8'h00;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_last;
   logic              dst_busy;
   logic              in_ready, in_ready_m;
   logic [N-1:0][7:0] blk_o, blk_o_m;
   logic              wr_en, wr_en_m;
   logic              pad_flag, pad_flag_m;
   logic [15:0]       blk_cnt, blk_cnt_m;

   logic [N-1:0][7:0] cap;
   int                exp_cnt;
   int                total = 0;
   int                bad = 0;

   always #5 clk = ~clk;

   // stand-in for mod_reg16: captures the block on wr_en
   always @(posedge clk) if (wr_en) cap <= blk_o;

   mod_blk_loader #(.N(N), .PAD_BYTE(PADB), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .dst_busy(dst_busy), .blk_o(blk_o), .wr_en(wr_en),
      .pad_flag(pad_flag), .blk_cnt(blk_cnt)
   );

   mod_blk_loader #(.N(N), .PAD_BYTE(PADB), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready_m),
      .dst_busy(dst_busy), .blk_o(blk_o_m), .wr_en(wr_en_m),
      .pad_flag(pad_flag_m), .blk_cnt(blk_cnt_m)
   );

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; dst_busy = 1'b0;
      @(negedge clk);
      cyc();
      total++;
      if (in_ready !== 1'b0 || wr_en !== 1'b0 || in_ready_m !== 1'b0) begin
         bad++;
         $display("FAIL rst_outs rdy=%b wr=%b rdy_m=%b req 0 0 0",
                  in_ready, wr_en, in_ready_m);
      end
      reset = 1'b0;
      #1;
      total++;
      if (blk_o !== '0 || pad_flag !== 1'b0 || blk_cnt !== 16'd0 ||
          blk_o_m !== '0 || in_ready !== 1'b1 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL rst_vals blk=%h pad=%b cnt=%h rdy=%b wr=%b",
                  blk_o, pad_flag, blk_cnt, in_ready, wr_en);
      end
      exp_cnt = 0;
   endtask

   // Sends one message and follows it through padding, optional
   // backpressure and issue, comparing against the expected block.
   task automatic run_msg(input logic [7:0] d[$], input bit last_full,
                          input int busy, input bit gaps,
                          input string nm);
      int n;
      int lat;
      logic [N-1:0][7:0] el, em;
      logic ep;
      n = d.size();
      for (int i = 0; i < N; i++) begin
         el[i] = (i < n) ? d[i] : PADB;
         em[N-1-i] = el[i];
      end
      ep = (n < N);
      lat = N - n + 1;
      for (int i = 0; i < n; i++) begin
         while (gaps && ($urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            cyc();
         end
         total++;
         if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL %s_fill_rdy byte=%0d rdy=%b wr=%b req 1 0",
                     nm, i, in_ready, wr_en);
         end
         in_valid = 1'b1;
         in_data = d[i];
         in_last = (i == n - 1) && (n < N || last_full);
         dst_busy = (busy > 0);
         cyc();
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      for (int c = 1; c < lat + busy; c++) begin
         total++;
         if (wr_en !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_wait c=%0d wr=%b rdy=%b req 0 0",
                     nm, c, wr_en, in_ready);
         end
         if (c >= lat) begin
            total++;
            if (blk_o !== el || pad_flag !== ep) begin
               bad++;
               $display("FAIL %s_hold c=%0d blk=%h req %h pad=%b req %b",
                        nm, c, blk_o, el, pad_flag, ep);
            end
         end
         if (busy > 0) begin
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
         end
         cyc();
      end
      in_valid = 1'b0;
      dst_busy = 1'b0;
      #1;
      total++;
      if (wr_en !== 1'b1 || wr_en_m !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s_wr wr=%b wr_m=%b rdy=%b req 1 1 0",
                  nm, wr_en, wr_en_m, in_ready);
      end
      total++;
      if (blk_o !== el || blk_o_m !== em) begin
         bad++;
         $display("FAIL %s_blk got=%h req %h msb got=%h req %h",
                  nm, blk_o, el, blk_o_m, em);
      end
      total++;
      if (pad_flag !== ep || pad_flag_m !== ep) begin
         bad++;
         $display("FAIL %s_pad got=%b/%b req %b",
                  nm, pad_flag, pad_flag_m, ep);
      end
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      cyc();
      total++;
      if (wr_en !== 1'b0 || in_ready !== 1'b1 ||
          blk_cnt !== 16'(exp_cnt) || blk_cnt_m !== 16'(exp_cnt)) begin
         bad++;
         $display("FAIL %s_after wr=%b rdy=%b cnt=%0d req 0 1 %0d",
                  nm, wr_en, in_ready, blk_cnt, exp_cnt);
      end
      total++;
      if (cap !== el) begin
         bad++;
         $display("FAIL %s_cap got=%h req %h", nm, cap, el);
      end
   endtask

   task automatic test_full();
      logic [7:0] d[$];
      for (int i = 0; i < N; i++) d.push_back(8'(i));
      run_msg(d, 1'b0, 0, 1'b0, "full");
   endtask

   task automatic test_short();
      logic [7:0] d[$];
      for (int i = 0; i < 5; i++) d.push_back(8'hA0 + 8'(i));
      run_msg(d, 1'b0, 0, 1'b0, "short");
   endtask

   task automatic test_backpressure();
      logic [7:0] d[$];
      for (int i = 0; i < N; i++) d.push_back(8'($urandom));
      run_msg(d, 1'b1, 10, 1'b0, "bp");
   endtask

   task automatic test_one_byte();
      logic [7:0] d[$];
      d.push_back(8'h55);
      run_msg(d, 1'b0, 0, 1'b0, "one");
   endtask

   task automatic test_reset_mid();
      logic [7:0] d[$];
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data = 8'($urandom);
         in_last = 1'b0;
         cyc();
      end
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL rmid_during rdy=%b wr=%b req 0 0",
                  in_ready, wr_en);
      end
      cyc();
      reset = 1'b0;
      #1;
      exp_cnt = 0;
      total++;
      if (blk_o !== '0 || blk_cnt !== 16'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rmid_vals blk=%h cnt=%0d rdy=%b req 0 0 1",
                  blk_o, blk_cnt, in_ready);
      end
      for (int i = 0; i < N; i++) d.push_back(8'h10 + 8'(i));
      run_msg(d, 1'b0, 0, 1'b0, "rmid");
   endtask

   task automatic test_gaps();
      logic [7:0] d[$];
      for (int b = 0; b < 3; b++) begin
         d.delete();
         for (int i = 0; i < N; i++) d.push_back(8'($urandom));
         run_msg(d, 1'b0, 0, 1'b1, "gaps");
      end
      total++;
      if (blk_cnt !== 16'(exp_cnt)) begin
         bad++;
         $display("FAIL gaps_cnt got=%0d req %0d", blk_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d[$];
      for (int b = 0; b < 8; b++) begin
         int n;
         d.delete();
         n = $urandom_range(1, N);
         for (int i = 0; i < n; i++) d.push_back(8'($urandom));
         run_msg(d, 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                 "b2b");
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_short();
      test_backpressure();
      test_one_byte();
      test_reset_mid();
      test_reset();
      test_gaps();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
